// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-requester Wishbone classic-cycle arbiter for the UART gateway.
// Requester 0 is the UART configuration engine and requester 1 is the RC transfer
// handler. The single master port drives the UART IP.
// A grant is locked to the owner's cyc, and one idle GAP cycle separates grants.
// Optional watchdog abort: compile with `define WB_ARB_TIMEOUT_EN.
//
// Handshake: a requester asks for the bus by raising sX_cyc. Once it owns the bus,
// its stb/we/adr/dat_w/sel pass straight through to the master port. The slave's
// m_ack reaches only the owner and qualifies the broadcast read data. The grant is
// held until the owner drops cyc, or until the watchdog aborts it.
module wb_arbiter2 #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SEL_W          = 4,
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_cyc,
  input  logic              s0_stb,
  input  logic              s0_we,
  input  logic [ADDR_W-1:0] s0_adr,
  input  logic [DATA_W-1:0] s0_dat_w,
  input  logic [SEL_W-1:0]  s0_sel,
  output logic              s0_ack,
  output logic              s0_err,
  output logic [DATA_W-1:0] s0_dat_r,
  input  logic              s1_cyc,
  input  logic              s1_stb,
  input  logic              s1_we,
  input  logic [ADDR_W-1:0] s1_adr,
  input  logic [DATA_W-1:0] s1_dat_w,
  input  logic [SEL_W-1:0]  s1_sel,
  output logic              s1_ack,
  output logic              s1_err,
  output logic [DATA_W-1:0] s1_dat_r,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_dat_w,
  output logic [SEL_W-1:0]  m_sel,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_dat_r,
  output logic [1:0]        owner,
  output logic              timeout_evt,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_bad
    $error("wb_arbiter2: TIMEOUT_CYCLES out of range 2..65535");
  end

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;   // 1 = requester 1 won the last grant
  logic              own0, own1;
  logic              pick1;
  logic              wd_hit;
  logic              sel_cyc, sel_stb, sel_we;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_dat_w;
  logic [SEL_W-1:0]  sel_sel;

  assign own0 = (state_q == S_OWN0);
  assign own1 = (state_q == S_OWN1);

  // Pick the winner among current requests: a sole requester wins. On a tie,
  // the winner is either the requester that did not win last time, or requester 0.
  always_comb begin
    pick1 = s1_cyc;
    if (s0_cyc && s1_cyc) begin
      pick1 = (PRIO_MODE == 1) ? 1'b0 : ~last_q;
    end
  end

  // Grant-state transitions. GAP also arbitrates, so that a handover reaches
  // the next owner two cycles after the release.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (s0_cyc || s1_cyc) begin
          last_d  = pick1;
          state_d = pick1 ? S_OWN1 : S_OWN0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN0:  if (!s0_cyc || wd_hit) state_d = S_GAP;
      S_OWN1:  if (!s1_cyc || wd_hit) state_d = S_GAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered grant state and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Steer the owner's request signals to the master side. When nobody owns
  // the bus, everything on the master side is driven to 0.
  always_comb begin
    sel_cyc   = 1'b0;
    sel_stb   = 1'b0;
    sel_we    = 1'b0;
    sel_adr   = '0;
    sel_dat_w = '0;
    sel_sel   = '0;
    if (own0) begin
      sel_cyc   = s0_cyc;
      sel_stb   = s0_stb;
      sel_we    = s0_we;
      sel_adr   = s0_adr;
      sel_dat_w = s0_dat_w;
      sel_sel   = s0_sel;
    end else if (own1) begin
      sel_cyc   = s1_cyc;
      sel_stb   = s1_stb;
      sel_we    = s1_we;
      sel_adr   = s1_adr;
      sel_dat_w = s1_dat_w;
      sel_sel   = s1_sel;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;

  assign wd_hit = (own0 | own1) & sel_stb & ~m_ack & (wd_q == WD_LIMIT);

  // Count owned strobe cycles that get no ack. The count restarts on every
  // new grant and on every ack.
  always_comb begin
    wd_d = wd_q;
    if (((state_q == S_IDLE) || (state_q == S_GAP)) && (s0_cyc || s1_cyc)) begin
      wd_d = '0;
    end else if (m_ack) begin
      wd_d = '0;
    end else if ((own0 || own1) && sel_stb) begin
      wd_d = wd_q + 16'd1;
    end
  end

  // Registered watchdog count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign wd_hit = 1'b0;
`endif

  // On a watchdog abort, cyc and stb are cut in the same cycle.
  assign m_cyc   = sel_cyc & ~wd_hit;
  assign m_stb   = sel_stb & ~wd_hit;
  assign m_we    = sel_we;
  assign m_adr   = sel_adr;
  assign m_dat_w = sel_dat_w;
  assign m_sel   = sel_sel;

  assign s0_ack   = own0 & m_ack;
  assign s1_ack   = own1 & m_ack;
  assign s0_err   = own0 & wd_hit;
  assign s1_err   = own1 & wd_hit;
  assign s0_dat_r = m_dat_r;
  assign s1_dat_r = m_dat_r;

  assign owner       = {own1, own0};
  assign timeout_evt = wd_hit;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed tests for wb_arbiter2, plus a small scoreboard of
// expected data and grant order. Two instances share the requester stimulus:
// r_* is round-robin and p_* is fixed priority. Both use TIMEOUT_CYCLES = 8.
`timescale 1ns/1ps
module tb_wb_arbiter2;

  logic        clk, rst;
  logic        s0_cyc, s0_stb, s0_we, s1_cyc, s1_stb, s1_we, m_ack;
  logic [31:0] s0_adr, s0_dat_w, s1_adr, s1_dat_w, m_dat_r;
  logic [3:0]  s0_sel, s1_sel;

  logic        r_s0_ack, r_s0_err, r_s1_ack, r_s1_err, r_m_cyc, r_m_stb, r_m_we, r_tevt;
  logic [31:0] r_s0_dat_r, r_s1_dat_r, r_m_adr, r_m_dat_w;
  logic [3:0]  r_m_sel;
  logic [1:0]  r_owner, r_state;

  logic        p_s0_ack, p_s0_err, p_s1_ack, p_s1_err, p_m_cyc, p_m_stb, p_m_we, p_tevt;
  logic [31:0] p_s0_dat_r, p_s1_dat_r, p_m_adr, p_m_dat_w;
  logic [3:0]  p_m_sel;
  logic [1:0]  p_owner, p_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  grant_q[$];

  wb_arbiter2 #(.PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .s0_cyc(s0_cyc), .s0_stb(s0_stb), .s0_we(s0_we), .s0_adr(s0_adr),
    .s0_dat_w(s0_dat_w), .s0_sel(s0_sel), .s0_ack(r_s0_ack), .s0_err(r_s0_err),
    .s0_dat_r(r_s0_dat_r),
    .s1_cyc(s1_cyc), .s1_stb(s1_stb), .s1_we(s1_we), .s1_adr(s1_adr),
    .s1_dat_w(s1_dat_w), .s1_sel(s1_sel), .s1_ack(r_s1_ack), .s1_err(r_s1_err),
    .s1_dat_r(r_s1_dat_r),
    .m_cyc(r_m_cyc), .m_stb(r_m_stb), .m_we(r_m_we), .m_adr(r_m_adr),
    .m_dat_w(r_m_dat_w), .m_sel(r_m_sel), .m_ack(m_ack), .m_dat_r(m_dat_r),
    .owner(r_owner), .timeout_evt(r_tevt), .dbg_state(r_state)
  );

  wb_arbiter2 #(.PRIO_MODE(1), .TIMEOUT_CYCLES(8)) dut_p (
    .clk(clk), .rst(rst),
    .s0_cyc(s0_cyc), .s0_stb(s0_stb), .s0_we(s0_we), .s0_adr(s0_adr),
    .s0_dat_w(s0_dat_w), .s0_sel(s0_sel), .s0_ack(p_s0_ack), .s0_err(p_s0_err),
    .s0_dat_r(p_s0_dat_r),
    .s1_cyc(s1_cyc), .s1_stb(s1_stb), .s1_we(s1_we), .s1_adr(s1_adr),
    .s1_dat_w(s1_dat_w), .s1_sel(s1_sel), .s1_ack(p_s1_ack), .s1_err(p_s1_err),
    .s1_dat_r(p_s1_dat_r),
    .m_cyc(p_m_cyc), .m_stb(p_m_stb), .m_we(p_m_we), .m_adr(p_m_adr),
    .m_dat_w(p_m_dat_w), .m_sel(p_m_sel), .m_ack(m_ack), .m_dat_r(m_dat_r),
    .owner(p_owner), .timeout_evt(p_tevt), .dbg_state(p_state)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge, where new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    s0_cyc = 1'b0; s0_stb = 1'b0; s0_we = 1'b0; s0_adr = '0; s0_dat_w = '0; s0_sel = '0;
    s1_cyc = 1'b0; s1_stb = 1'b0; s1_we = 1'b0; s1_adr = '0; s1_dat_w = '0; s1_sel = '0;
    m_ack = 1'b0; m_dat_r = '0;
  endtask

  task automatic reset_dut();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b1;
    s0_adr = 32'h44; s0_dat_w = 32'h5A; s0_sel = 4'h3; m_ack = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total++;
    if (r_owner !== 2'b00 || r_state !== 2'b00) begin
      bad++; $display("FAIL reset_state owner=%b state=%b want 00/00", r_owner, r_state);
    end
    total++;
    if ({r_m_cyc, r_m_stb, r_m_we, r_s0_ack, r_s0_err, r_s1_ack, r_s1_err, r_tevt} !== 8'h00) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000000",
                      {r_m_cyc, r_m_stb, r_m_we, r_s0_ack, r_s0_err, r_s1_ack, r_s1_err, r_tevt});
    end
    total++;
    if ({r_m_adr, r_m_dat_w, r_m_sel} !== 68'h0) begin
      bad++; $display("FAIL reset_bus adr=%h dat=%h sel=%h want 0", r_m_adr, r_m_dat_w, r_m_sel);
    end
    tick();
    rst = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    total++;
    if (r_owner !== 2'b00) begin
      bad++; $display("FAIL reset_latency owner=%b want=00", r_owner);
    end
    tick();
    @(negedge clk);
    total++;
    if (r_owner !== 2'b01 || r_m_cyc !== 1'b1 || r_m_we !== 1'b1 || r_m_adr !== 32'h44 ||
        r_m_dat_w !== 32'h5A || r_m_sel !== 4'h3) begin
      bad++; $display("FAIL reset_first_grant owner=%b cyc=%b adr=%h dat=%h sel=%h want 01/1/44/5a/3",
                      r_owner, r_m_cyc, r_m_adr, r_m_dat_w, r_m_sel);
    end
    // Assert reset in the middle of an owned cycle that has an ack in flight.
    tick();
    m_ack = 1'b1; rst = 1'b1;
    @(negedge clk);
    total++;
    if (r_owner !== 2'b00 || r_m_cyc !== 1'b0 || r_s0_ack !== 1'b0 || r_state !== 2'b00) begin
      bad++; $display("FAIL reset_midrun owner=%b cyc=%b ack=%b state=%b want 00/0/0/00",
                      r_owner, r_m_cyc, r_s0_ack, r_state);
    end
    tick();
    rst = 1'b0; m_ack = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (r_owner !== 2'b01) begin
      bad++; $display("FAIL reset_regrant owner=%b want=01", r_owner);
    end
    drive_idle();
    repeat (2) tick();
  endtask

  task automatic test_single_write();
    int   ack_cnt;
    logic s0_seen;
    logic [31:0] exp_d;
    ack_cnt = 0; s0_seen = 1'b0;
    reset_dut();
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_we = 1'b1;
    s1_adr = 32'h0C; s1_dat_w = 32'h83; s1_sel = 4'hF;
    exp_q.push_back(32'h83);
    tick();
    for (int i = 0; i < 4; i++) begin
      m_ack = (i == 3);
      @(negedge clk);
      if (i == 0) begin
        exp_d = exp_q.pop_front();
        total++;
        if (r_owner !== 2'b10 || {r_m_cyc, r_m_stb, r_m_we} !== 3'b111 || r_m_adr !== 32'h0C ||
            r_m_dat_w !== exp_d || r_m_sel !== 4'hF) begin
          bad++; $display("FAIL write_mirror owner=%b ctl=%b adr=%h dat=%h sel=%h want 10/111/0c/%h/f",
                          r_owner, {r_m_cyc, r_m_stb, r_m_we}, r_m_adr, r_m_dat_w, r_m_sel, exp_d);
        end
      end
      if (r_s1_ack) ack_cnt++;
      if (r_s0_ack) s0_seen = 1'b1;
      tick();
    end
    m_ack = 1'b0; s1_cyc = 1'b0; s1_stb = 1'b0;
    @(negedge clk);
    if (r_s1_ack) ack_cnt++;
    total++;
    if (r_m_cyc !== 1'b0 || r_owner !== 2'b10) begin
      bad++; $display("FAIL write_release cyc=%b owner=%b want 0/10", r_m_cyc, r_owner);
    end
    tick();
    m_ack = 1'b1;   // stray ack during GAP
    @(negedge clk);
    total++;
    if (r_owner !== 2'b00 || r_s0_ack !== 1'b0 || r_s1_ack !== 1'b0) begin
      bad++; $display("FAIL write_gap_ack owner=%b acks=%b%b want 00/00", r_owner, r_s1_ack, r_s0_ack);
    end
    tick();
    m_ack = 1'b0;
    total++;
    if (ack_cnt != 1 || s0_seen !== 1'b0) begin
      bad++; $display("FAIL write_ack_count s1_acks=%0d s0_seen=%b want 1/0", ack_cnt, s0_seen);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int s0_left, s1_left;
    logic [1:0]  exp_own;
    logic [31:0] exp_d;
    logic got0, got1;
    s0_left = 3; s1_left = 3;
    reset_dut();
    for (int k = 0; k < 6; k++) grant_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_adr = 32'h100;
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_adr = 32'h200;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_own = grant_q.pop_front();
      m_ack = 1'b1; m_dat_r = 32'(32'hA0 + k);
      exp_q.push_back(32'(32'hA0 + k));
      @(negedge clk);
      exp_d = exp_q.pop_front();
      total++;
      if (r_owner !== exp_own || {r_s1_ack, r_s0_ack} !== exp_own) begin
        bad++; $display("FAIL rr_grant[%0d] owner=%b acks=%b%b want=%b", k, r_owner, r_s1_ack, r_s0_ack, exp_own);
      end
      total++;
      if (r_s0_dat_r !== exp_d || r_s1_dat_r !== exp_d) begin
        bad++; $display("FAIL rr_data[%0d] got=%h/%h want=%h", k, r_s0_dat_r, r_s1_dat_r, exp_d);
      end
      got0 = r_s0_ack; got1 = r_s1_ack;
      tick();
      m_ack = 1'b0;
      if (got0) begin s0_cyc = 1'b0; s0_stb = 1'b0; s0_left--; end
      if (got1) begin s1_cyc = 1'b0; s1_stb = 1'b0; s1_left--; end
      @(negedge clk);
      total++;
      if (r_m_cyc !== 1'b0) begin
        bad++; $display("FAIL rr_release[%0d] cyc=%b want=0", k, r_m_cyc);
      end
      tick();
      s0_cyc = (s0_left > 0); s0_stb = (s0_left > 0);
      s1_cyc = (s1_left > 0); s1_stb = (s1_left > 0);
      @(negedge clk);
      total++;
      if (r_owner !== 2'b00 || r_m_cyc !== 1'b0) begin
        bad++; $display("FAIL rr_gap[%0d] owner=%b cyc=%b want 00/0", k, r_owner, r_m_cyc);
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_fixed_priority();
    int s0_left;
    logic [1:0]  exp_own;
    logic [31:0] exp_d;
    logic got0, got1;
    s0_left = 3;
    reset_dut();
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_adr = 32'h100;
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_adr = 32'h200;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_own = (k < 3) ? 2'b01 : 2'b10;
      m_ack = 1'b1; m_dat_r = 32'(32'hB0 + k);
      exp_q.push_back(32'(32'hB0 + k));
      @(negedge clk);
      exp_d = exp_q.pop_front();
      total++;
      if (p_owner !== exp_own || {p_s1_ack, p_s0_ack} !== exp_own) begin
        bad++; $display("FAIL fp_grant[%0d] owner=%b acks=%b%b want=%b", k, p_owner, p_s1_ack, p_s0_ack, exp_own);
      end
      total++;
      if (p_s0_dat_r !== exp_d) begin
        bad++; $display("FAIL fp_data[%0d] got=%h want=%h", k, p_s0_dat_r, exp_d);
      end
      got0 = p_s0_ack; got1 = p_s1_ack;
      tick();
      m_ack = 1'b0;
      if (got0) begin s0_cyc = 1'b0; s0_stb = 1'b0; s0_left--; end
      if (got1) begin s1_cyc = 1'b0; s1_stb = 1'b0; end
      tick();
      s0_cyc = (s0_left > 0); s0_stb = (s0_left > 0);
      @(negedge clk);
      total++;
      if (p_owner !== 2'b00 || p_m_cyc !== 1'b0) begin
        bad++; $display("FAIL fp_gap[%0d] owner=%b cyc=%b want 00/0", k, p_owner, p_m_cyc);
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_locked_burst();
    logic [31:0] exp_d;
    reset_dut();
    s0_cyc = 1'b1;
    tick();
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_adr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      s0_stb = 1'b1; s0_adr = 32'(16 * (i + 1)); m_ack = 1'b0;
      @(negedge clk);
      total++;
      if (r_owner !== 2'b01 || r_s0_ack !== 1'b0 || r_s1_ack !== 1'b0) begin
        bad++; $display("FAIL burst_wait[%0d] owner=%b acks=%b%b want 01/00", i, r_owner, r_s1_ack, r_s0_ack);
      end
      tick();
      m_ack = 1'b1; m_dat_r = 32'(32'h11 * (i + 1));
      exp_q.push_back(32'(32'h11 * (i + 1)));
      @(negedge clk);
      exp_d = exp_q.pop_front();
      total++;
      if (r_s0_ack !== 1'b1 || r_s1_ack !== 1'b0 || r_s0_dat_r !== exp_d || r_owner !== 2'b01) begin
        bad++; $display("FAIL burst_read[%0d] ack=%b%b dat=%h owner=%b want 01/%h/01",
                        i, r_s1_ack, r_s0_ack, r_s0_dat_r, r_owner, exp_d);
      end
      tick();
    end
    m_ack = 1'b0; s0_cyc = 1'b0; s0_stb = 1'b0;
    @(negedge clk);
    total++;
    if (r_owner !== 2'b01 || r_m_cyc !== 1'b0) begin
      bad++; $display("FAIL burst_drop owner=%b cyc=%b want 01/0", r_owner, r_m_cyc);
    end
    tick();
    @(negedge clk);
    total++;
    if (r_owner !== 2'b00) begin
      bad++; $display("FAIL burst_gap owner=%b want=00", r_owner);
    end
    tick();
    @(negedge clk);
    total++;
    if (r_owner !== 2'b10 || r_m_adr !== 32'h300) begin
      bad++; $display("FAIL burst_handover owner=%b adr=%h want 10/300", r_owner, r_m_adr);
    end
    drive_idle();
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    reset_dut();
`ifdef WB_ARB_TIMEOUT_EN
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_adr = 32'h400;
    tick();
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_adr = 32'h500;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++;
      if ({r_s0_err, r_s1_err, r_tevt, r_m_cyc} !== ((i == 8) ? 4'b0110 : 4'b0001)) begin
        bad++; $display("FAIL to_s1[%0d] err0/err1/evt/cyc=%b want=%b", i,
                        {r_s0_err, r_s1_err, r_tevt, r_m_cyc}, (i == 8) ? 4'b0110 : 4'b0001);
      end
      tick();
    end
    s1_cyc = 1'b0; s1_stb = 1'b0;
    @(negedge clk);
    total++;
    if (r_owner !== 2'b00 || r_tevt !== 1'b0) begin
      bad++; $display("FAIL to_gap owner=%b evt=%b want 00/0", r_owner, r_tevt);
    end
    tick();
    for (int i = 1; i <= 11; i++) begin
      m_ack = (i == 3);
      @(negedge clk);
      if (i == 1) begin
        total++;
        if (r_owner !== 2'b01) begin
          bad++; $display("FAIL to_regrant owner=%b want=01", r_owner);
        end
      end
      total++;
      if ({r_s0_err, r_s1_err, r_tevt, r_m_cyc} !== ((i == 11) ? 4'b1010 : 4'b0001)) begin
        bad++; $display("FAIL to_s0[%0d] err0/err1/evt/cyc=%b want=%b", i,
                        {r_s0_err, r_s1_err, r_tevt, r_m_cyc}, (i == 11) ? 4'b1010 : 4'b0001);
      end
      tick();
    end
`else
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_adr = 32'h400;
    tick();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if ({r_s1_err, r_tevt, r_m_cyc, r_owner} !== 5'b00110) begin
        bad++; $display("FAIL hold[%0d] err/evt/cyc/owner=%b want=00110", i,
                        {r_s1_err, r_tevt, r_m_cyc, r_owner});
      end
      tick();
    end
`endif
    drive_idle();
    repeat (2) tick();
  endtask

  // Safety net: ends the run if the test sequence ever stalls.
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_write();
    test_round_robin();
    test_fixed_priority();
    test_locked_burst();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
